// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: shared types and constants for the multiplexed
// seven-segment display driver (seven_seg_scan and bcd_to_seg).
package seven_seg_pkg;

  localparam int NUM_DIGITS = 3;

  typedef logic [6:0] seg_t;   // {g,f,e,d,c,b,a}, active-low
  typedef logic [3:0] bcd_t;   // one BCD digit, codes 10..15 invalid

  localparam seg_t SEG_BLANK = 7'h7F;
  localparam seg_t SEG_DASH  = 7'b0111111;

  // Three captured digits, hundreds in the top nibble.
  typedef struct packed {
    bcd_t hund;
    bcd_t tens;
    bcd_t units;
  } digits_t;

endpackage

// File: rtl/bcd_to_seg.sv
// bcd_to_seg: combinational BCD to active-low seven-segment decoder.
// Codes above 9 decode to a dash so bad counter data is visible.
module bcd_to_seg
  import seven_seg_pkg::*;
(
  input  bcd_t iCode,
  output seg_t oSeg
);

  // Segment lookup, bit order g..a, a lit segment is 0.
  always_comb begin
    case (iCode)
      4'd0:    oSeg = 7'b1000000;
      4'd1:    oSeg = 7'b1111001;
      4'd2:    oSeg = 7'b0100100;
      4'd3:    oSeg = 7'b0110000;
      4'd4:    oSeg = 7'b0011001;
      4'd5:    oSeg = 7'b0010010;
      4'd6:    oSeg = 7'b0000010;
      4'd7:    oSeg = 7'b1111000;
      4'd8:    oSeg = 7'b0000000;
      4'd9:    oSeg = 7'b0010000;
      default: oSeg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan.sv
// seven_seg_scan: 3-digit multiplexed seven-segment driver.
// Captures BCD digits on iLoad into a pending register, promotes them to
// the display register only at a frame boundary (no torn frames), and
// scans the digits onto a shared active-low segment bus with a blanking
// window at the start of every slot.
// Optional build macro SEVEN_SEG_LZB_EN enables leading-zero blanking.
module seven_seg_scan
  import seven_seg_pkg::*;
#(
  parameter int DIV   = 50000,  // cycles per digit slot, >= 2
  parameter int BLANK = 500     // all-off cycles at slot start, < DIV
)
(
  input  logic                  iClk,
  input  logic                  iRst_n,
  input  logic [3:0]            iDigit1,
  input  logic [3:0]            iDigit2,
  input  logic [3:0]            iDigit3,
  input  logic                  iLoad,
  output logic [6:0]            oSeg,
  output logic [NUM_DIGITS-1:0] oAn
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_C  = CNT_W'(BLANK);

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [1:0]            idx_q, idx_d;
  digits_t               pend_q, pend_d;
  logic                  pend_vld_q, pend_vld_d;
  digits_t               disp_q, disp_d;
  seg_t                  seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;

  logic                  slot_end;
  logic                  frame_end;
  digits_t               ld_val;
  bcd_t                  sel_code;
  logic [NUM_DIGITS-1:0] sel_an;
  logic                  lzb;
  seg_t                  dec_seg;

  // Slot/digit scan counters and the pending/display digit registers.
  always_comb begin
    slot_end   = (cnt_q == CNT_LAST);
    frame_end  = slot_end && (idx_q == 2'd2);
    ld_val     = '{hund: iDigit3, tens: iDigit2, units: iDigit1};

    cnt_d      = slot_end ? '0 : cnt_q + 1'b1;
    idx_d      = idx_q;
    if (slot_end) begin
      idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
    end

    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    disp_d     = disp_q;
    if (iLoad) begin
      pend_d     = ld_val;
      pend_vld_d = 1'b1;
    end
    // A load on the boundary edge goes straight to the display.
    if (frame_end) begin
      pend_vld_d = 1'b0;
      if (iLoad) begin
        disp_d = ld_val;
      end else if (pend_vld_q) begin
        disp_d = pend_q;
      end
    end
  end

  // Select the digit and enable for the current slot.
  always_comb begin
    case (idx_q)
      2'd0:    begin sel_code = disp_q.units; sel_an = 3'b110; end
      2'd1:    begin sel_code = disp_q.tens;  sel_an = 3'b101; end
      default: begin sel_code = disp_q.hund;  sel_an = 3'b011; end
    endcase
  end

  bcd_to_seg u_dec (
    .iCode (sel_code),
    .oSeg  (dec_seg)
  );

  // Leading-zero blanking decision for the selected digit.
  always_comb begin
`ifdef SEVEN_SEG_LZB_EN
    lzb = ((idx_q == 2'd2) && (disp_q.hund == 4'd0)) ||
          ((idx_q == 2'd1) && (disp_q.hund == 4'd0) && (disp_q.tens == 4'd0));
`else
    lzb = 1'b0;
`endif
  end

  // Next output bus value: all off in the blanking window, else one digit.
  always_comb begin
    if (cnt_q < BLANK_C) begin
      an_d  = '1;
      seg_d = SEG_BLANK;
    end else begin
      an_d  = sel_an;
      seg_d = lzb ? SEG_BLANK : dec_seg;
    end
  end

  // State and registered outputs; outputs move together on one edge.
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      cnt_q      <= '0;
      idx_q      <= 2'd0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      disp_q     <= '0;
      seg_q      <= SEG_BLANK;
      an_q       <= '1;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      disp_q     <= disp_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
    end
  end

  assign oSeg = seg_q;
  assign oAn  = an_q;

endmodule

// File: doc/seven_seg_scan.md
# seven_seg_scan

Multiplexed 3-digit seven-segment display driver placed directly downstream of the 3-digit BCD counter. Captures the counter's units/tens/hundreds digits, decodes them to segment patterns, and time-multiplexes them onto a shared active-low segment bus with per-digit active-low enables. Displayed values change only on frame boundaries, so the display never shows a torn mix of old and new digits.

## Interface
- `DIV`, 50000: clock cycles per digit slot; must be ≥ 2.
- `BLANK`, 500: cycles at the start of each slot with all digits off (anti-ghosting); must satisfy 0 ≤ BLANK < DIV.
- `iClk` in 1: single clock.
- `iRst_n` in 1: reset, synchronous, active-low.
- `iDigit1` in 4: units BCD digit.
- `iDigit2` in 4: tens BCD digit.
- `iDigit3` in 4: hundreds BCD digit.
- `iLoad` in 1: single-cycle strobe; sample `iDigit1..3` this cycle.
- `oSeg` out 7: segments {g,f,e,d,c,b,a}, active-low.
- `oAn` out 3: digit enables, active-low; bit 0 = units, bit 2 = hundreds.

## Operation
- **Slot counter** `cnt`: width clog2(DIV); runs 0..DIV-1, then wraps to 0.
- **Digit index** `idx`: runs 0→1→2→0; advances when `cnt == DIV-1`.
- **Frame boundary**: `idx == 2` and `cnt == DIV-1`.
- **Pending register**:
  - `iLoad` = 1 → stores `iDigit1..3` and sets the pending flag.
  - A later `iLoad` before the frame boundary overwrites it (last load wins).
- **Display register**:
  - At a frame boundary with the pending flag set, takes the pending value; the flag clears.
  - If `iLoad` coincides with a frame boundary, it takes the `iDigit1..3` values directly; the pending flag ends clear.
- **Slot output**:
  - `cnt < BLANK` → `oAn = 3'b111`, `oSeg = 7'h7F`.
  - Otherwise → `oAn` has a single 0 at bit `idx`, and `oSeg` shows the decoded display digit `idx`.
- **Decode** (active-low, bit order g..a):
  - 0 = `7'b1000000`, 1 = `7'b1111001`, 2 = `7'b0100100`, 3 = `7'b0110000`, 4 = `7'b0011001`.
  - 5 = `7'b0010010`, 6 = `7'b0000010`, 7 = `7'b1111000`, 8 = `7'b0000000`, 9 = `7'b0010000`.
  - Codes 10–15 → dash, `7'b0111111`.
- **Reset**:
  - `cnt = 0`, `idx = 0`, pending and display registers = 0, pending flag clear.
  - `oSeg = 7'h7F`, `oAn = 3'b111`.
  - Reset mid-slot or mid-frame discards any pending load.

## Timing
- `oSeg` and `oAn` are registered. State (`cnt`, `idx`, display register) at edge n appears on the outputs after edge n+1: latency of 1 cycle.
- **After reset release**:
  - First cycle: outputs still at reset values.
  - Units digit is enabled from cycle BLANK+1 to cycle DIV.
- **Frame period**: 3·DIV cycles.
- **Load-to-display latency**: at most 3·DIV + 1 cycles. Minimum is 1 cycle, when the load coincides with the boundary.
- **Glitch-free bus**: `oAn` and `oSeg` change on the same edge; only one `oAn` bit is ever low.

## Configuration
- **`SEVEN_SEG_LZB_EN` defined**: leading-zero blanking.
  - Hundreds digit = 0 → blanked (`oSeg = 7'h7F`); its `oAn` bit still follows the scan.
  - Tens digit is blanked when both hundreds and tens = 0.
  - Units digit is never blanked.
  - Invalid codes are never blanked.
- **Macro undefined**: every digit is always decoded; 0 shows as `7'b1000000`.

## Structure
- **Package `seven_seg_pkg`**:
  - `NUM_DIGITS` = 3.
  - `SEG_BLANK` = `7'h7F`, `SEG_DASH` = `7'b0111111`.
  - 7-bit segment typedef and a 4-bit BCD typedef.
- **Sub-module `bcd_to_seg`**: purely combinational, 4-bit code → 7-bit active-low pattern, dash for codes > 9. Instantiated once on the mux-selected digit.

## Test plan
All scenarios use DIV=8, BLANK=2.
- **Reset**: hold `iRst_n` = 0 for 3 cycles → `oAn = 3'b111` and `oSeg = 7'h7F` throughout. After release, `oAn = 3'b110` first appears on cycle 3 with `oSeg = 7'b1000000`.
- **Scan**: load 3/2/1 on digits 1/2/3, then run 2 frames.
  - `oAn` cycles 110→101→011, each low for 6 cycles and separated by 2 all-off cycles.
  - `oSeg` shows 0110000 / 0100100 / 1111001 respectively.
- **Anti-tear**: display shows 123. Load 456 mid-slot of the units digit.
  - Tens and hundreds keep showing 2 and 1 for the rest of the frame.
  - 456 appears from the next frame on all three digits.
- **Simultaneous load and boundary**: assert `iLoad` with 789 exactly at the frame boundary → the next units slot shows 9 (`7'b0010000`). A second load of 000 in the same frame is shown one frame later.
- **Invalid code**: `iDigit2` = 4'hC → tens slot shows `7'b0111111`. Without `SEVEN_SEG_LZB_EN`, value 005 shows 0, 0, 5.
- **Blanking and mid-frame reset**:
  - With `SEVEN_SEG_LZB_EN`, value 005 → hundreds and tens slots output `7'h7F` while their enables still scan.
  - Units shows `7'b0010010`.
  - Reset asserted mid-frame → outputs return to reset values on the next edge, and the pending load is lost.
